// File: rtl/id_ex_stage_pkg.sv
// Shared widths, ALU opcodes, the ID/EX register layout and forwarding selects
// for the ID/EX stage of the 5-stage core.
package id_ex_stage_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int ALU_SEL_W  = 6;

  // ALU opcodes; code 0 is the ALU default path and is what a bubble carries.
  localparam logic [ALU_SEL_W-1:0] ALU_DEFAULT = 6'd0;
  localparam logic [ALU_SEL_W-1:0] ALU_ADD     = 6'd1;
  localparam logic [ALU_SEL_W-1:0] ALU_SUB     = 6'd2;
  localparam logic [ALU_SEL_W-1:0] ALU_AND     = 6'd3;
  localparam logic [ALU_SEL_W-1:0] ALU_OR      = 6'd4;
  localparam logic [ALU_SEL_W-1:0] ALU_XOR     = 6'd5;
  localparam logic [ALU_SEL_W-1:0] ALU_SLL     = 6'd6;
  localparam logic [ALU_SEL_W-1:0] ALU_SRL     = 6'd7;
  localparam logic [ALU_SEL_W-1:0] ALU_SRA     = 6'd8;
  localparam logic [ALU_SEL_W-1:0] ALU_SLT     = 6'd9;
  localparam logic [ALU_SEL_W-1:0] ALU_SLTU    = 6'd10;

  // Where a forwarded operand came from.
  typedef enum logic [1:0] {
    FWD_REG   = 2'd0,
    FWD_MEMWB = 2'd1,
    FWD_EXMEM = 2'd2
  } fwd_sel_e;

  // Everything held in the ID/EX register. All-zero is a bubble.
  typedef struct packed {
    logic                  valid;
    logic [DATA_W-1:0]     pc;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [DATA_W-1:0]     rs1_data;
    logic [DATA_W-1:0]     rs2_data;
    logic [DATA_W-1:0]     imm;
    logic [ALU_SEL_W-1:0]  alu_sel;
    logic                  src_a_pc;
    logic                  src_b_imm;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
  } id_ex_t;

endpackage

// File: rtl/id_ex_stage_fwd_unit.sv
// Per-operand forwarding mux: the youngest in-flight writer of rs wins, x0 is
// never forwarded, otherwise the register file value captured in ID is used.
module fwd_unit
  import id_ex_stage_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [DATA_W-1:0]     reg_data,
  input  logic                  exmem_reg_write,
  input  logic [REG_ADDR_W-1:0] exmem_rd,
  input  logic [DATA_W-1:0]     exmem_result,
  input  logic                  memwb_reg_write,
  input  logic [REG_ADDR_W-1:0] memwb_rd,
  input  logic [DATA_W-1:0]     memwb_result,
  output logic [DATA_W-1:0]     fwd_data,
  output fwd_sel_e              fwd_sel
);

  logic exmem_hit;
  logic memwb_hit;

  assign exmem_hit = exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs);
  assign memwb_hit = memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs);

  // Priority select: EX/MEM is younger than MEM/WB, so it shadows it.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    fwd_data = reg_data;
    fwd_sel  = FWD_REG;
    if (exmem_hit) begin
      fwd_data = exmem_result;
      fwd_sel  = FWD_EXMEM;
    end else if (memwb_hit) begin
      fwd_data = memwb_result;
      fwd_sel  = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and EX-side operand
// forwarding; drives the ALU inputs and the EX/MEM control directly.
module id_ex_stage
  import id_ex_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [DATA_W-1:0]     id_pc,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [DATA_W-1:0]     id_rs1_data,
  input  logic [DATA_W-1:0]     id_rs2_data,
  input  logic [DATA_W-1:0]     id_imm,
  input  logic [ALU_SEL_W-1:0]  id_alu_sel,
  input  logic                  id_src_a_pc,
  input  logic                  id_src_b_imm,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  id_mem_write,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic                  exmem_reg_write,
  input  logic [REG_ADDR_W-1:0] exmem_rd,
  input  logic [DATA_W-1:0]     exmem_result,
  input  logic                  memwb_reg_write,
  input  logic [REG_ADDR_W-1:0] memwb_rd,
  input  logic [DATA_W-1:0]     memwb_result,
  output logic                  load_use_stall_o,
  output logic                  ex_valid,
  output logic [ALU_SEL_W-1:0]  ex_alu_ctl,
  output logic [DATA_W-1:0]     ex_alu_a,
  output logic [DATA_W-1:0]     ex_alu_b,
  output logic [DATA_W-1:0]     ex_store_data,
  output logic [DATA_W-1:0]     ex_pc,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write
);

  id_ex_t            ex_q;
  id_ex_t            id_fields;
  logic              load_use;
  logic [DATA_W-1:0] fwd_rs1;
  logic [DATA_W-1:0] fwd_rs2;
  // Source selects are not consumed here; kept for debug visibility.
  fwd_sel_e          fwd_sel_rs1_unused;
  fwd_sel_e          fwd_sel_rs2_unused;

  // A load in EX cannot feed a dependent instruction in ID in time.
  assign load_use = ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) && id_valid &&
                    ((id_use_rs1 && (id_rs1 == ex_q.rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_q.rd)));

  // A taken branch kills the dependent instruction anyway, so no freeze needed.
  assign load_use_stall_o = load_use && !flush_i;

  // Pack decode fields; control is qualified by id_valid.
  always_comb begin
    id_fields           = '0;
    id_fields.valid     = id_valid;
    id_fields.pc        = id_pc;
    id_fields.rs1       = id_rs1;
    id_fields.rs2       = id_rs2;
    id_fields.rs1_data  = id_rs1_data;
    id_fields.rs2_data  = id_rs2_data;
    id_fields.imm       = id_imm;
    id_fields.alu_sel   = id_alu_sel;
    id_fields.src_a_pc  = id_src_a_pc;
    id_fields.src_b_imm = id_src_b_imm;
    id_fields.rd        = id_rd;
    id_fields.reg_write = id_reg_write && id_valid;
    id_fields.mem_read  = id_mem_read && id_valid;
    id_fields.mem_write = id_mem_write && id_valid;
  end

  // ID/EX register: reset > flush > stall hold > load-use bubble > capture.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs regardless of statement order.
    if (rst) begin
      ex_q <= '0;
    end else if (flush_i) begin
      ex_q <= '0;
    end else if (stall_i) begin
      ex_q <= ex_q;
    end else if (load_use) begin
      ex_q <= '0;
    end else begin
      ex_q <= id_fields;
    end
  end

  fwd_unit u_fwd_rs1 (
    .rs              (ex_q.rs1),
    .reg_data        (ex_q.rs1_data),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_result    (memwb_result),
    .fwd_data        (fwd_rs1),
    .fwd_sel         (fwd_sel_rs1_unused)
  );

  fwd_unit u_fwd_rs2 (
    .rs              (ex_q.rs2),
    .reg_data        (ex_q.rs2_data),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_result    (memwb_result),
    .fwd_data        (fwd_rs2),
    .fwd_sel         (fwd_sel_rs2_unused)
  );

  assign ex_valid      = ex_q.valid;
  assign ex_alu_ctl    = ex_q.alu_sel;
  assign ex_alu_a      = ex_q.src_a_pc  ? ex_q.pc  : fwd_rs1;
  assign ex_alu_b      = ex_q.src_b_imm ? ex_q.imm : fwd_rs2;
  assign ex_store_data = fwd_rs2;
  assign ex_pc         = ex_q.pc;
  assign ex_rd         = ex_q.rd;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_mem_read   = ex_q.mem_read;
  assign ex_mem_write  = ex_q.mem_write;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline register plus EX-side operand forwarding for the 5-stage RISC-V core; it sits directly upstream of the ALU.
- Captures decoded fields each cycle and resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
- Detects load-use hazards and inserts a bubble.
- Drives ALU ctl/A/B plus store data and control into EX/MEM.

Parameters:
DATA_W, 32, datapath width
REG_ADDR_W, 5, register index width
ALU_SEL_W, 6, ALU opcode width (same encoding as `ALU_* in def.h)

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
id_valid  in  1  decode slot holds a real instruction
id_pc  in  DATA_W  PC of decoded instruction
id_rs1, id_rs2  in  REG_ADDR_W  source indices
id_use_rs1, id_use_rs2  in  1  instruction reads rs1/rs2
id_rs1_data, id_rs2_data  in  DATA_W  register file read data
id_imm  in  DATA_W  sign-extended immediate
id_alu_sel  in  ALU_SEL_W  ALU opcode
id_src_a_pc  in  1  ALU A = PC (else rs1)
id_src_b_imm  in  1  ALU B = imm (else rs2)
id_rd  in  REG_ADDR_W  destination index
id_reg_write, id_mem_read, id_mem_write  in  1  control
stall_i  in  1  global freeze (memory wait)
flush_i  in  1  branch/jump taken, kill ID/EX
exmem_reg_write  in  1
exmem_rd  in  REG_ADDR_W
exmem_result  in  DATA_W  EX/MEM forwarding source
memwb_reg_write  in  1
memwb_rd  in  REG_ADDR_W
memwb_result  in  DATA_W  MEM/WB forwarding source
load_use_stall_o  out  1  freeze PC and IF/ID this cycle
ex_valid  out  1
ex_alu_ctl  out  ALU_SEL_W  to ALU ALUctl
ex_alu_a, ex_alu_b  out  DATA_W  to ALU A/B
ex_store_data  out  DATA_W  forwarded rs2 value
ex_pc  out  DATA_W
ex_rd  out  REG_ADDR_W
ex_reg_write, ex_mem_read, ex_mem_write  out  1

Behaviour:
- Interface: single clock clk; rst is synchronous and active-high.
- On rst, all registered fields clear to 0. This makes ex_valid, ex_reg_write, ex_mem_read, ex_mem_write and ex_alu_ctl 0, and ex_alu_ctl=0 is the ALU default path.
- Register update priority per rising edge: rst > flush_i (bubble) > stall_i (hold all) > load_use (bubble) > capture id_*.
- Bubble: valid, reg_write, mem_read, mem_write and alu_sel are 0; data fields are don't-care but are also cleared to 0.
- Captured control (reg_write, mem_read, mem_write) is ANDed with id_valid.
- load_use condition is combinational: ex_valid & ex_mem_read & ex_rd!=0 & id_valid & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- load_use_stall_o = load_use & ~flush_i. Asserted with stall_i, the bubble is deferred until stall_i drops, but the output stays asserted.
- Forwarding is combinational from registered rs1/rs2 indices, evaluated every cycle including stalled cycles. Per operand:
  - EX/MEM match (reg_write & rd!=0 & rd==rsN) wins.
  - else MEM/WB match.
  - else the registered regfile data.
  - x0 is never forwarded.
- ex_alu_a = src_a_pc ? pc : fwd_rs1; ex_alu_b = src_b_imm ? imm : fwd_rs2; ex_store_data = fwd_rs2 always.
- Latency: one cycle, ID fields appear on ex_* the cycle after capture; forwarding adds zero cycles.
- Reset mid-stall or mid-load-use yields a bubble next cycle; load_use_stall_o is 0 after reset since ex_valid=0.

Decomposition:
- Shared package/def.h: DATA_W, REG_ADDR_W, ALU_SEL_W, `ALU_* codes, a packed id_ex_t struct holding all registered fields, and fwd_sel_e enum {FWD_REG, FWD_MEMWB, FWD_EXMEM}.
- Sub-module fwd_unit is instanced twice, once per operand: it maps rs, the two writer tuples and reg data to the forwarded value plus fwd_sel.

Test Plan:
- Reset: rst=1 for 2 cycles with id_valid=1 -> all ex_* 0, load_use_stall_o=0; first capture appears the cycle after rst deasserts.
- EX/MEM priority: reg rs1=x5, data 0x11; exmem rd=5 result 0x22 and memwb rd=5 result 0x33 both writing -> ex_alu_a=0x22; drop exmem_reg_write -> 0x33; set rd=0 on both -> 0x11.
- Load-use: lw x7 in EX (ex_mem_read=1, rd=7), ID add with rs2=x7 -> load_use_stall_o=1 one cycle; next ex_valid=0; following cycle add captured, load_use_stall_o=0.
- Flush over load-use: same setup with flush_i=1 -> load_use_stall_o=0, next ex_valid=0.
- Stall hold: capture addi (imm 0x7FF, alu_sel ALU_ADD), then stall_i=1 for 3 cycles while id_* changes -> ex_alu_b stays 0x7FF and ex_alu_ctl stays ALU_ADD; forwarding value still tracks exmem_result changes.
- Store/PC source: sw with src_b_imm=1, rs2 forwarded from MEM/WB 0xDEADBEEF -> ex_alu_b=imm, ex_store_data=0xDEADBEEF; auipc src_a_pc=1, pc 0x100 -> ex_alu_a=0x100.
